axi_adc_scan: RTL and testbench

//  AXI4-Lite-controlled, multi-channel ADC scan controller with sample FIFO. It replaces the

---
 rtl/axi_adc_pkg.sv | 38 +++
 rtl/axi_adc_scan_if.sv | 33 +++
 rtl/adc_sample_fifo.sv | 58 +++++
 rtl/axi_adc_scan.sv | 254 +++++++++++++++++++++++++
 tb/tb_axi_adc_scan.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_adc_pkg.sv
// rtl/axi_adc_pkg.sv - register map, bit positions, scan states and response codes for axi_adc_scan
package axi_adc_pkg;

    localparam logic [4:0] ADDR_CTL     = 5'h00;
    localparam logic [4:0] ADDR_CLK_DIV = 5'h04;
    localparam logic [4:0] ADDR_STATUS  = 5'h08;
    localparam logic [4:0] ADDR_DATA    = 5'h0C;
    localparam logic [4:0] ADDR_IRQ_THR = 5'h10;

    localparam int CTL_EN       = 0;
    localparam int CTL_CONT     = 1;
    localparam int CTL_START    = 2;
    localparam int CTL_FIFO_CLR = 3;
    localparam int CTL_MASK_LSB = 8;

    localparam int STAT_BUSY      = 0;
    localparam int STAT_EMPTY     = 1;
    localparam int STAT_FULL      = 2;
    localparam int STAT_OVF       = 3;
    localparam int STAT_LEVEL_LSB = 16;

    localparam int DATA_CH_LSB = 24;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CONV,
        ST_NEXT
    } scan_state_t;

endpackage

// File: rtl/axi_adc_scan_if.sv
// rtl/axi_adc_scan_if.sv - AXI4-Lite bus (5-bit address, 32-bit data) with master/slave modports
interface axi_adc_scan_if;
    import axi_adc_pkg::*;

    logic [4:0]  awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [4:0]  araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/adc_sample_fifo.sv
// rtl/adc_sample_fifo.sv - sync FWFT FIFO with push/pop/clr, full/empty/level and drop indication
// Ports: clk, rst (sync, active-high); push/din; pop/dout (head word, valid when !empty);
//        clr empties the FIFO; full, empty, level (0..DEPTH); overflow pulses when a push is dropped.
module adc_sample_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    input  logic             clr,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level,
    output logic             overflow
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (level == LVL_W'(DEPTH));
    assign empty    = (level == '0);
    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push  = push && (!full || do_pop);
    assign overflow = push && !do_push && !clr;
    assign dout     = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)      level <= level + LVL_W'(1);
            else if (!do_push && do_pop) level <= level - LVL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/axi_adc_scan.sv
// rtl/axi_adc_scan.sv - AXI4-Lite multi-channel ADC scan controller with sample FIFO and level irq
// Ports: aclk, areset (sync, active-high); s_axi (AXI4-Lite slave modport);
//        adc_clk (registered conversion clock), adc_ch_sel (analog mux select),
//        adc_data (ADC parallel output), irq (level: IRQ_THR!=0 && LEVEL>=IRQ_THR, registered).
module axi_adc_scan
    import axi_adc_pkg::*;
#(
    parameter  int DATA_W     = 8,
    parameter  int NUM_CH     = 4,
    parameter  int FIFO_DEPTH = 16,
    parameter  int DIV_W      = 16,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              aclk,
    input  logic              areset,
    axi_adc_scan_if.slave     s_axi,
    output logic              adc_clk,
    output logic [CH_W-1:0]   adc_ch_sel,
    input  logic [DATA_W-1:0] adc_data,
    output logic              irq
);
    localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int WORD_W = CH_W + DATA_W;

    logic              ctl_en;
    logic              ctl_cont;
    logic [NUM_CH-1:0] ctl_mask;
    logic [DIV_W-1:0]  clk_div;
    logic [7:0]        irq_thr;
    logic              ovf;

    logic              wr_fire;
    logic              rd_fire;
    logic              start_req;
    logic              start_en;
    logic [NUM_CH-1:0] start_mask;
    logic              clr_req;
    logic              ovf_clr;
    logic [31:0]       rd_word;

    scan_state_t       state;
    logic [DIV_W-1:0]  div_cnt;
    logic [DIV_W-1:0]  div_lat;
    logic              div_tick;
    logic [NUM_CH-1:0] mask_lat;
    logic              next_valid;
    logic [CH_W-1:0]   next_ch;

    logic              fifo_push;
    logic              fifo_pop;
    logic [WORD_W-1:0] fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic [LVL_W-1:0]  fifo_level;
    logic              fifo_ovf;
    logic              busy;

    logic              unused_axi;
    assign unused_axi = ^{s_axi.wstrb, s_axi.wdata};

    function automatic logic [CH_W-1:0] lowest_ch(input logic [NUM_CH-1:0] m);
        lowest_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i]) lowest_ch = CH_W'(i);
        end
    endfunction

    // ---------------- AXI-Lite handshakes ----------------
    assign wr_fire       = s_axi.awvalid && s_axi.wvalid && !s_axi.bvalid;
    assign s_axi.awready = wr_fire;
    assign s_axi.wready  = wr_fire;
    assign s_axi.bresp   = RESP_OKAY;
    assign rd_fire       = s_axi.arvalid && !s_axi.rvalid;
    assign s_axi.arready = rd_fire;
    assign s_axi.rresp   = RESP_OKAY;

    // START uses the EN/mask being written, so EN|START in one write launches a scan.
    assign start_req  = wr_fire && (s_axi.awaddr == ADDR_CTL) && s_axi.wdata[CTL_START];
    assign start_en   = s_axi.wdata[CTL_EN];
    assign start_mask = s_axi.wdata[CTL_MASK_LSB +: NUM_CH];
    assign clr_req    = wr_fire && (s_axi.awaddr == ADDR_CTL) && s_axi.wdata[CTL_FIFO_CLR];
    assign ovf_clr    = wr_fire && (s_axi.awaddr == ADDR_STATUS) && s_axi.wdata[STAT_OVF];
    assign fifo_pop   = rd_fire && (s_axi.araddr == ADDR_DATA);

    always_ff @(posedge aclk) begin
        if (areset) begin
            ctl_en       <= 1'b0;
            ctl_cont     <= 1'b0;
            ctl_mask     <= '0;
            clk_div      <= DIV_W'(4);
            irq_thr      <= '0;
            s_axi.bvalid <= 1'b0;
        end else if (wr_fire) begin
            s_axi.bvalid <= 1'b1;
            case (s_axi.awaddr)
                ADDR_CTL: begin
                    ctl_en   <= s_axi.wdata[CTL_EN];
                    ctl_cont <= s_axi.wdata[CTL_CONT];
                    ctl_mask <= s_axi.wdata[CTL_MASK_LSB +: NUM_CH];
                end
                ADDR_CLK_DIV: clk_div <= s_axi.wdata[DIV_W-1:0];
                ADDR_IRQ_THR: irq_thr <= s_axi.wdata[7:0];
                default: ;
            endcase
        end else if (s_axi.bready) begin
            s_axi.bvalid <= 1'b0;
        end
    end

    // A drop in the same cycle as the W1C wins so the event is never lost.
    always_ff @(posedge aclk) begin
        if (areset)        ovf <= 1'b0;
        else if (fifo_ovf) ovf <= 1'b1;
        else if (ovf_clr)  ovf <= 1'b0;
    end

    always_comb begin
        rd_word = '0;
        case (s_axi.araddr)
            ADDR_CTL: begin
                rd_word[CTL_EN]                  = ctl_en;
                rd_word[CTL_CONT]                = ctl_cont;
                rd_word[CTL_MASK_LSB +: NUM_CH]  = ctl_mask;
            end
            ADDR_CLK_DIV: rd_word[DIV_W-1:0] = clk_div;
            ADDR_STATUS: begin
                rd_word[STAT_BUSY]               = busy;
                rd_word[STAT_EMPTY]              = fifo_empty;
                rd_word[STAT_FULL]               = fifo_full;
                rd_word[STAT_OVF]                = ovf;
                rd_word[STAT_LEVEL_LSB +: 8]     = 8'(fifo_level);
            end
            ADDR_DATA: begin
                if (!fifo_empty) begin
                    rd_word[DATA_W-1:0]          = fifo_dout[DATA_W-1:0];
                    rd_word[DATA_CH_LSB +: 3]    = 3'(fifo_dout[WORD_W-1:DATA_W]);
                end
            end
            ADDR_IRQ_THR: rd_word[7:0] = irq_thr;
            default: ;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            s_axi.rvalid <= 1'b0;
            s_axi.rdata  <= '0;
        end else if (rd_fire) begin
            s_axi.rvalid <= 1'b1;
            s_axi.rdata  <= rd_word;
        end else if (s_axi.rready) begin
            s_axi.rvalid <= 1'b0;
        end
    end

    // ---------------- Scan FSM and adc_clk divider ----------------
    assign busy     = (state != ST_IDLE);
    assign div_tick = (div_cnt == div_lat);
    // Capture happens on the edge that drives adc_clk 1->0; an abort suppresses it.
    assign fifo_push = (state == ST_CONV) && div_tick && adc_clk && ctl_en;

    always_comb begin
        next_valid = 1'b0;
        next_ch    = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask_lat[i] && (i > int'(adc_ch_sel))) begin
                next_valid = 1'b1;
                next_ch    = CH_W'(i);
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state      <= ST_IDLE;
            adc_clk    <= 1'b0;
            adc_ch_sel <= '0;
            div_cnt    <= '0;
            div_lat    <= '0;
            mask_lat   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_req && start_en && (start_mask != '0)) begin
                        state      <= ST_SETTLE;
                        mask_lat   <= start_mask;
                        adc_ch_sel <= lowest_ch(start_mask);
                        div_cnt    <= '0;
                        div_lat    <= clk_div;
                        adc_clk    <= 1'b0;
                    end
                end
                default: begin
                    if (!ctl_en) begin
                        state   <= ST_IDLE;
                        adc_clk <= 1'b0;
                    end else begin
                        if (div_tick) begin
                            div_cnt <= '0;
                            div_lat <= clk_div;
                            adc_clk <= ~adc_clk;
                        end else begin
                            div_cnt <= div_cnt + DIV_W'(1);
                        end
                        case (state)
                            // SETTLE ends on the rising toggle; the falling one a half period
                            // later completes a full adc_clk period before the first capture.
                            ST_SETTLE: if (div_tick) state <= ST_CONV;
                            ST_CONV:   if (div_tick && adc_clk) state <= ST_NEXT;
                            ST_NEXT: begin
                                if (next_valid) begin
                                    adc_ch_sel <= next_ch;
                                    state      <= ST_CONV;
                                end else if (ctl_cont && (ctl_mask != '0)) begin
                                    mask_lat   <= ctl_mask;
                                    adc_ch_sel <= lowest_ch(ctl_mask);
                                    state      <= ST_CONV;
                                end else begin
                                    state   <= ST_IDLE;
                                    adc_clk <= 1'b0;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) irq <= 1'b0;
        else        irq <= (irq_thr != 8'd0) && (32'(fifo_level) >= 32'(irq_thr));
    end

    adc_sample_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk      (aclk),
        .rst      (areset),
        .push     (fifo_push),
        .din      ({adc_ch_sel, adc_data}),
        .pop      (fifo_pop),
        .clr      (clr_req),
        .dout     (fifo_dout),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level),
        .overflow (fifo_ovf)
    );

endmodule

// File: tb/tb_axi_adc_scan.sv
// tb/tb_axi_adc_scan.sv - directed self-checking bench for axi_adc_scan
module tb_axi_adc_scan;
    import axi_adc_pkg::*;

    logic       aclk = 1'b0;
    logic       areset;
    logic       adc_clk;
    logic [1:0] adc_ch_sel;
    logic [7:0] adc_data;
    logic       irq;

    always #5 aclk = ~aclk;

    axi_adc_scan_if axi ();

    // Each channel presents a distinct sample: 0xA0 + channel.
    assign adc_data = 8'hA0 | {6'd0, adc_ch_sel};

    axi_adc_scan #(
        .DATA_W     (8),
        .NUM_CH     (4),
        .FIFO_DEPTH (16),
        .DIV_W      (16)
    ) dut (
        .aclk       (aclk),
        .areset     (areset),
        .s_axi      (axi),
        .adc_clk    (adc_clk),
        .adc_ch_sel (adc_ch_sel),
        .adc_data   (adc_data),
        .irq        (irq)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    int last_rise = 0;
    int adc_period = 0;
    logic [1:0] fall_ch[$];

    always @(posedge aclk) cyc++;
    always @(posedge adc_clk) begin
        adc_period = cyc - last_rise;
        last_rise  = cyc;
    end
    always @(negedge adc_clk) fall_ch.push_back(adc_ch_sel);

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data);
        int n;
        axi.awaddr  = addr;
        axi.wdata   = data;
        axi.wstrb   = 4'hF;
        axi.awvalid = 1'b1;
        axi.wvalid  = 1'b1;
        axi.bready  = 1'b1;
        n = 0;
        do begin
            @(negedge aclk);
            n++;
        end while (!axi.awready && n < 100);
        if (!axi.awready) expect_eq("aw_timeout", 32'd0, 32'd1);
        @(posedge aclk);
        #1;
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
        n = 0;
        while (!axi.bvalid && n < 100) begin
            @(negedge aclk);
            n++;
        end
        if (!axi.bvalid) expect_eq("b_timeout", 32'd0, 32'd1);
        @(posedge aclk);
        #1;
    endtask

    task automatic axi_read(input logic [4:0] addr, output logic [31:0] data);
        int n;
        axi.araddr  = addr;
        axi.arvalid = 1'b1;
        axi.rready  = 1'b1;
        n = 0;
        do begin
            @(negedge aclk);
            n++;
        end while (!axi.arready && n < 100);
        if (!axi.arready) expect_eq("ar_timeout", 32'd0, 32'd1);
        @(posedge aclk);
        #1;
        axi.arvalid = 1'b0;
        n = 0;
        while (!axi.rvalid && n < 100) begin
            @(negedge aclk);
            n++;
        end
        if (!axi.rvalid) expect_eq("r_timeout", 32'd0, 32'd1);
        data = axi.rdata;
        @(posedge aclk);
        #1;
    endtask

    task automatic check_reg(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        logic [31:0] v;
        axi_read(addr, v);
        expect_eq(tag, v, exp);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic count_adc_high(input int cycles, output int highs);
        highs = 0;
        repeat (cycles) begin
            @(negedge aclk);
            if (adc_clk) highs++;
        end
        @(posedge aclk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        int highs;
        int falls;
        int n;
        int irq_early;
        int stalls;
        int bdrop;
        logic prev;

        axi.awaddr = '0; axi.awvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0;
        axi.bready = 1'b0; axi.araddr = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;
        areset = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        areset = 1'b0;

        // T1 reset state
        expect_eq("rst_adc_clk", adc_clk, 0);
        expect_eq("rst_irq", irq, 0);
        expect_eq("rst_ch_sel", adc_ch_sel, 0);
        check_reg("rst_ctl", ADDR_CTL, 32'h0);
        check_reg("rst_clk_div", ADDR_CLK_DIV, 32'd4);
        check_reg("rst_status", ADDR_STATUS, 32'h0000_0002);
        check_reg("rst_irq_thr", ADDR_IRQ_THR, 32'h0);
        count_adc_high(20, highs);
        expect_eq("rst_adc_clk_idle", highs, 0);

        // T2 single scan, mask 1011, CLK_DIV=4
        fall_ch.delete();
        axi_write(ADDR_CTL, 32'h0000_0B05);
        axi_read(ADDR_STATUS, v);
        expect_eq("t2_busy", v & 32'h1, 32'h1);
        idle_cycles(40);
        check_reg("t2_status", ADDR_STATUS, 32'h0003_0000);
        expect_eq("t2_adc_period", adc_period, 10);
        expect_eq("t2_nfalls", fall_ch.size(), 3);
        if (fall_ch.size() == 3) begin
            expect_eq("t2_sel0", fall_ch[0], 0);
            expect_eq("t2_sel1", fall_ch[1], 1);
            expect_eq("t2_sel2", fall_ch[2], 3);
        end
        check_reg("t2_data0", ADDR_DATA, 32'h0000_00A0);
        check_reg("t2_data1", ADDR_DATA, 32'h0100_00A1);
        check_reg("t2_data2", ADDR_DATA, 32'h0300_00A3);
        check_reg("t2_status_empty", ADDR_STATUS, 32'h0000_0002);
        check_reg("t2_ctl_selfclr", ADDR_CTL, 32'h0000_0B01);

        // T3 continuous on channel 2 with irq threshold 5
        axi_write(ADDR_IRQ_THR, 32'd5);
        axi_write(ADDR_CLK_DIV, 32'd1);
        axi_write(ADDR_CTL, 32'h0000_0407);
        falls = 0;
        n = 0;
        irq_early = 0;
        prev = adc_clk;
        while (falls < 5 && n < 200) begin
            @(negedge aclk);
            n++;
            if (prev && !adc_clk) falls++;
            prev = adc_clk;
            if (falls < 5 && irq) irq_early++;
        end
        expect_eq("t3_fall_count", falls, 5);
        expect_eq("t3_irq_early", irq_early, 0);
        expect_eq("t3_irq_lag", irq, 0);
        @(negedge aclk);
        expect_eq("t3_irq_rise", irq, 1);
        axi_write(ADDR_CTL, 32'h0);
        for (int i = 0; i < 5; i++) check_reg("t3_data_ch2", ADDR_DATA, 32'h0200_00A2);
        idle_cycles(2);
        expect_eq("t3_irq_fall", irq, 0);
        axi_write(ADDR_CTL, 32'h0000_0008);

        // T4 overflow
        axi_write(ADDR_IRQ_THR, 32'd16);
        axi_write(ADDR_CLK_DIV, 32'd0);
        axi_write(ADDR_CTL, 32'h0000_0107);
        idle_cycles(60);
        check_reg("t4_full_ovf", ADDR_STATUS, 32'h0010_000D);
        expect_eq("t4_irq_full", irq, 1);
        axi_write(ADDR_CTL, 32'h0);
        check_reg("t4_stopped", ADDR_STATUS, 32'h0010_000C);
        axi_write(ADDR_STATUS, 32'h0000_0008);
        check_reg("t4_ovf_w1c", ADDR_STATUS, 32'h0010_0004);
        axi_write(ADDR_CTL, 32'h0000_0008);
        check_reg("t4_fifo_clr", ADDR_STATUS, 32'h0000_0002);
        idle_cycles(2);
        expect_eq("t4_irq_clr", irq, 0);

        // T5 abort mid-conversion, then ignored STARTs
        axi_write(ADDR_CLK_DIV, 32'd4);
        axi_write(ADDR_CTL, 32'h0000_0105);
        n = 0;
        do begin
            @(negedge aclk);
            n++;
        end while (!adc_clk && n < 100);
        expect_eq("t5_conv_reached", adc_clk, 1);
        axi_write(ADDR_CTL, 32'h0);
        expect_eq("t5_abort_clk", adc_clk, 0);
        check_reg("t5_abort_status", ADDR_STATUS, 32'h0000_0002);
        count_adc_high(20, highs);
        expect_eq("t5_abort_quiet", highs, 0);
        check_reg("t5_no_partial", ADDR_STATUS, 32'h0000_0002);
        axi_write(ADDR_CTL, 32'h0000_0005);
        count_adc_high(20, highs);
        expect_eq("t5_mask0_clk", highs, 0);
        check_reg("t5_mask0_status", ADDR_STATUS, 32'h0000_0002);
        axi_write(ADDR_CTL, 32'h0000_0104);
        check_reg("t5_en0_status", ADDR_STATUS, 32'h0000_0002);

        // T6 AXI back-to-back writes with bready held low
        axi.awaddr  = ADDR_IRQ_THR;
        axi.wdata   = 32'h22;
        axi.wstrb   = 4'hF;
        axi.awvalid = 1'b1;
        axi.wvalid  = 1'b1;
        axi.bready  = 1'b0;
        @(negedge aclk);
        expect_eq("t6_aw_first", axi.awready, 1);
        @(posedge aclk);
        #1;
        axi.awaddr = ADDR_CLK_DIV;
        axi.wdata  = 32'd7;
        stalls = 0;
        bdrop  = 0;
        repeat (5) begin
            @(negedge aclk);
            if (axi.awready) stalls++;
            if (!axi.bvalid) bdrop++;
        end
        expect_eq("t6_aw_stalled", stalls, 0);
        expect_eq("t6_bvalid_held", bdrop, 0);
        expect_eq("t6_bresp", axi.bresp, 0);
        @(posedge aclk);
        #1;
        axi.bready = 1'b1;
        @(posedge aclk);
        #1;
        @(negedge aclk);
        expect_eq("t6_aw_second", axi.awready, 1);
        @(posedge aclk);
        #1;
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
        @(negedge aclk);
        expect_eq("t6_b_second", axi.bvalid, 1);
        @(posedge aclk);
        #1;
        check_reg("t6_thr_rb", ADDR_IRQ_THR, 32'h22);
        check_reg("t6_div_rb", ADDR_CLK_DIV, 32'd7);
        check_reg("t6_unmapped_14", 5'h14, 32'h0);
        check_reg("t6_unmapped_1c", 5'h1C, 32'h0);
        check_reg("t6_data_empty", ADDR_DATA, 32'h0);
        check_reg("t6_level_zero", ADDR_STATUS, 32'h0000_0002);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
